// File: rtl/slu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | slu_pkg                                                              |
// | Store/load unit shared types: MemOp encodings, access sizes, FSM.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package slu_pkg;

  localparam logic [2:0] MEMOP_B  = 3'b000;
  localparam logic [2:0] MEMOP_H  = 3'b001;
  localparam logic [2:0] MEMOP_W  = 3'b010;
  localparam logic [2:0] MEMOP_BU = 3'b100;
  localparam logic [2:0] MEMOP_HU = 3'b101;

  // Access size is carried by MemOp[1:0]; MemOp[2] selects zero extension.
  localparam logic [1:0] SZ_B = MEMOP_B[1:0];
  localparam logic [1:0] SZ_H = MEMOP_H[1:0];

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RSP  = 2'd2,
    OUT  = 2'd3
  } state_e;

endpackage
`default_nettype wire

// File: rtl/slu_align.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | slu_align                                                            |
// | Combinational store lane placement, load extraction/extension and    |
// | misalignment detection.                                              |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module slu_align
  import slu_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_off,
  input  logic [31:0] i_st_data,
  output logic [3:0]  o_wstrb,
  output logic [31:0] o_wdata,
  output logic        o_misaligned,
  input  logic [2:0]  i_ld_op,
  input  logic [1:0]  i_ld_off,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic        ld_sext;

  always_comb begin
    o_wstrb      = 4'hF;
    o_wdata      = i_st_data;
    o_misaligned = |i_off;
    case (i_size)
      SZ_B: begin
        o_wstrb      = 4'b0001 << i_off;
        o_wdata      = {4{i_st_data[7:0]}};
        o_misaligned = 1'b0;
      end
      SZ_H: begin
        o_wstrb      = 4'b0011 << i_off;
        o_wdata      = {2{i_st_data[15:0]}};
        o_misaligned = i_off[0];
      end
      default: ;
    endcase
  end

  always_comb begin
    ld_byte = i_rdata[7:0];
    case (i_ld_off)
      2'd1:    ld_byte = i_rdata[15:8];
      2'd2:    ld_byte = i_rdata[23:16];
      2'd3:    ld_byte = i_rdata[31:24];
      default: ;
    endcase
    ld_half = i_ld_off[1] ? i_rdata[31:16] : i_rdata[15:0];
    ld_sext = ~i_ld_op[2];
    case (i_ld_op[1:0])
      SZ_B:    o_ld_data = {{24{ld_sext & ld_byte[7]}}, ld_byte};
      SZ_H:    o_ld_data = {{16{ld_sext & ld_half[15]}}, ld_half};
      default: o_ld_data = i_rdata;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/slu.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | slu                                                                  |
// | Store/load unit: single-outstanding memory access between exu/wbu.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module slu
  import slu_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic        i_reg_wena,
  input  logic [1:0]  i_reg_sel,
  input  logic        i_MemWr,
  input  logic        i_MemRe,
  input  logic [2:0]  i_MemOp,
  input  logic [31:0] i_ALUout,
  input  logic [31:0] i_src1,
  input  logic [31:0] i_src2,
  input  logic [31:0] i_imm,
  input  logic [31:0] i_pc,
  input  logic [31:0] i_inst,
  output logic        o_mem_req_valid,
  input  logic        i_mem_req_ready,
  output logic [31:0] o_mem_addr,
  output logic        o_mem_wen,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_wstrb,
  input  logic        i_mem_rsp_valid,
  input  logic [31:0] i_mem_rdata,
  input  logic        i_mem_rsp_err,
  output logic        o_mem_rsp_ready,
  output logic        o_valid,
  input  logic        i_ready,
  output logic        o_reg_wena,
  output logic [1:0]  o_reg_sel,
  output logic [31:0] o_ALUout,
  output logic [31:0] o_src1,
  output logic [31:0] o_imm,
  output logic [31:0] o_pc,
  output logic [31:0] o_inst,
  output logic [31:0] o_rdata,
  output logic        o_fault
);

  localparam int             CNT_W    = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              reg_wena_q, reg_wena_d;
  logic [1:0]        reg_sel_q, reg_sel_d;
  logic [31:0]       aluout_q, aluout_d;
  logic [31:0]       src1_q, src1_d;
  logic [31:0]       imm_q, imm_d;
  logic [31:0]       pc_q, pc_d;
  logic [31:0]       inst_q, inst_d;
  logic [2:0]        memop_q, memop_d;
  logic              is_load_q, is_load_d;
  logic [31:0]       mem_addr_q, mem_addr_d;
  logic              mem_wen_q, mem_wen_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [3:0]        mem_wstrb_q, mem_wstrb_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              fault_q, fault_d;

  logic [3:0]  st_wstrb;
  logic [31:0] st_wdata;
  logic        misaligned;
  logic [31:0] ld_data;
  logic        is_mem;

  slu_align u_align (
    .i_size       (i_MemOp[1:0]),
    .i_off        (i_ALUout[1:0]),
    .i_st_data    (i_src2),
    .o_wstrb      (st_wstrb),
    .o_wdata      (st_wdata),
    .o_misaligned (misaligned),
    .i_ld_op      (memop_q),
    .i_ld_off     (aluout_q[1:0]),
    .i_rdata      (i_mem_rdata),
    .o_ld_data    (ld_data)
  );

  assign is_mem = i_MemWr | i_MemRe;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    reg_wena_d  = reg_wena_q;
    reg_sel_d   = reg_sel_q;
    aluout_d    = aluout_q;
    src1_d      = src1_q;
    imm_d       = imm_q;
    pc_d        = pc_q;
    inst_d      = inst_q;
    memop_d     = memop_q;
    is_load_d   = is_load_q;
    mem_addr_d  = mem_addr_q;
    mem_wen_d   = mem_wen_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;
    rdata_d     = rdata_q;
    fault_d     = fault_q;
    case (state_q)
      IDLE: begin
        if (i_valid) begin
          reg_wena_d  = i_reg_wena;
          reg_sel_d   = i_reg_sel;
          aluout_d    = i_ALUout;
          src1_d      = i_src1;
          imm_d       = i_imm;
          pc_d        = i_pc;
          inst_d      = i_inst;
          memop_d     = i_MemOp;
          is_load_d   = i_MemRe & ~i_MemWr;
          rdata_d     = '0;
          fault_d     = 1'b0;
          mem_addr_d  = '0;
          mem_wen_d   = 1'b0;
          mem_wdata_d = '0;
          mem_wstrb_d = '0;
          if (is_mem && misaligned) begin
            fault_d = 1'b1;
            state_d = OUT;
          end else if (is_mem) begin
            // Store wins when both MemWr and MemRe are set.
            mem_addr_d  = {i_ALUout[31:2], 2'b00};
            mem_wen_d   = i_MemWr;
            mem_wdata_d = i_MemWr ? st_wdata : '0;
            mem_wstrb_d = i_MemWr ? st_wstrb : '0;
            state_d     = REQ;
          end else begin
            state_d = OUT;
          end
        end
      end
      REQ: begin
        if (i_mem_req_ready) begin
          cnt_d   = '0;
          state_d = RSP;
        end
      end
      RSP: begin
        cnt_d = cnt_q + 1'b1;
        if (i_mem_rsp_valid) begin
          rdata_d = is_load_q ? ld_data : '0;
          fault_d = i_mem_rsp_err;
          state_d = OUT;
        end else if (cnt_q == CNT_LAST) begin
          rdata_d = '0;
          fault_d = 1'b1;
          state_d = OUT;
        end
      end
      OUT: begin
        if (i_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      reg_wena_q  <= 1'b0;
      reg_sel_q   <= '0;
      aluout_q    <= '0;
      src1_q      <= '0;
      imm_q       <= '0;
      pc_q        <= '0;
      inst_q      <= '0;
      memop_q     <= '0;
      is_load_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wen_q   <= 1'b0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
      rdata_q     <= '0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      reg_wena_q  <= reg_wena_d;
      reg_sel_q   <= reg_sel_d;
      aluout_q    <= aluout_d;
      src1_q      <= src1_d;
      imm_q       <= imm_d;
      pc_q        <= pc_d;
      inst_q      <= inst_d;
      memop_q     <= memop_d;
      is_load_q   <= is_load_d;
      mem_addr_q  <= mem_addr_d;
      mem_wen_q   <= mem_wen_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
      rdata_q     <= rdata_d;
      fault_q     <= fault_d;
    end
  end

  assign o_ready         = (state_q == IDLE);
  assign o_mem_req_valid = (state_q == REQ);
  assign o_mem_rsp_ready = (state_q == RSP);
  assign o_valid         = (state_q == OUT);
  assign o_mem_addr      = mem_addr_q;
  assign o_mem_wen       = mem_wen_q;
  assign o_mem_wdata     = mem_wdata_q;
  assign o_mem_wstrb     = mem_wstrb_q;
  assign o_reg_wena      = reg_wena_q;
  assign o_reg_sel       = reg_sel_q;
  assign o_ALUout        = aluout_q;
  assign o_src1          = src1_q;
  assign o_imm           = imm_q;
  assign o_pc            = pc_q;
  assign o_inst          = inst_q;
  assign o_rdata         = rdata_q;
  assign o_fault         = fault_q;

endmodule
`default_nettype wire

// File: tb/tb_slu.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_slu                                                               |
// | Randomized transactions against a timeline/arithmetic model of slu.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_slu;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        i_rst, i_valid, i_reg_wena, i_MemWr, i_MemRe;
  logic [1:0]  i_reg_sel;
  logic [2:0]  i_MemOp;
  logic [31:0] i_ALUout, i_src1, i_src2, i_imm, i_pc, i_inst;
  logic        i_mem_req_ready, i_mem_rsp_valid, i_mem_rsp_err, i_ready;
  logic [31:0] i_mem_rdata;
  logic        o_ready, o_mem_req_valid, o_mem_wen, o_mem_rsp_ready, o_valid;
  logic        o_reg_wena, o_fault;
  logic [1:0]  o_reg_sel;
  logic [3:0]  o_mem_wstrb;
  logic [31:0] o_mem_addr, o_mem_wdata, o_ALUout, o_src1, o_imm, o_pc, o_inst, o_rdata;

  always #5 clk = ~clk;

  slu #(.TIMEOUT(TO)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_reg_wena(i_reg_wena), .i_reg_sel(i_reg_sel), .i_MemWr(i_MemWr),
    .i_MemRe(i_MemRe), .i_MemOp(i_MemOp), .i_ALUout(i_ALUout),
    .i_src1(i_src1), .i_src2(i_src2), .i_imm(i_imm), .i_pc(i_pc), .i_inst(i_inst),
    .o_mem_req_valid(o_mem_req_valid), .i_mem_req_ready(i_mem_req_ready),
    .o_mem_addr(o_mem_addr), .o_mem_wen(o_mem_wen), .o_mem_wdata(o_mem_wdata),
    .o_mem_wstrb(o_mem_wstrb), .i_mem_rsp_valid(i_mem_rsp_valid),
    .i_mem_rdata(i_mem_rdata), .i_mem_rsp_err(i_mem_rsp_err),
    .o_mem_rsp_ready(o_mem_rsp_ready), .o_valid(o_valid), .i_ready(i_ready),
    .o_reg_wena(o_reg_wena), .o_reg_sel(o_reg_sel), .o_ALUout(o_ALUout),
    .o_src1(o_src1), .o_imm(o_imm), .o_pc(o_pc), .o_inst(o_inst),
    .o_rdata(o_rdata), .o_fault(o_fault)
  );

  typedef struct {
    logic [31:0] alu, src1, src2, imm, pc, inst, rdata;
    logic        wena, wr, re, err, none, spur;
    logic [1:0]  sel;
    logic [2:0]  op;
    int          w1, w2, d, rst_at;
  } txn_t;

  typedef struct {
    bit          mem, mis;
    int          lat;
    logic [31:0] addr, wdata, rdata;
    logic [3:0]  wstrb;
    logic        wen, fault;
  } exp_t;

  int   n_vec = 0;
  int   n_err = 0;
  int   ph    = -1;
  txn_t ct;
  exp_t ce;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: expected outputs and output-valid cycle from the access rules.
  function automatic exp_t model(input txn_t t);
    exp_t        e;
    int          size, off;
    logic [63:0] v, mask;
    bit          tmo;
    size    = (t.op[1:0] == 2'd0) ? 1 : (t.op[1:0] == 2'd1) ? 2 : 4;
    off     = int'(t.alu[1:0]);
    e.mem   = t.wr || t.re;
    e.mis   = e.mem && ((off % size) != 0);
    e.addr  = t.alu & 32'hFFFF_FFFC;
    e.wen   = t.wr;
    e.wstrb = 4'(((1 << size) - 1) << off);
    for (int k = 0; k < 4; k++) e.wdata[8*k +: 8] = t.src2[8*(k % size) +: 8];
    e.rdata = 32'h0;
    e.fault = 1'b0;
    tmo     = t.none || (t.w2 >= TO);
    if (!e.mem) e.lat = 1;
    else if (e.mis) begin e.lat = 1; e.fault = 1'b1; end
    else if (tmo) begin e.lat = 2 + t.w1 + TO; e.fault = 1'b1; end
    else begin
      e.lat   = 3 + t.w1 + t.w2;
      e.fault = t.err;
      if (t.re && !t.wr) begin
        mask = (64'd1 << (8 * size)) - 64'd1;
        v    = ({32'h0, t.rdata} >> (8 * off)) & mask;
        if (size < 4 && !t.op[2] && v[8*size-1]) v = v | ~mask;
        e.rdata = v[31:0];
      end
    end
    return e;
  endfunction

  function automatic txn_t mk(input logic [31:0] alu, input logic wr, input logic re,
                              input logic [2:0] op);
    txn_t t;
    t.alu = alu; t.wr = wr; t.re = re; t.op = op;
    t.src1 = 32'h1111_0001; t.src2 = 32'h0; t.imm = 32'h0000_0AB0;
    t.pc = 32'h8000_0100; t.inst = 32'h0000_0013; t.rdata = 32'h0;
    t.wena = 1'b1; t.sel = 2'd1; t.err = 1'b0; t.none = 1'b0; t.spur = 1'b0;
    t.w1 = 0; t.w2 = 0; t.d = 0; t.rst_at = 0;
    return t;
  endfunction

  always @(negedge clk) begin
    bit er, ev, erq, ers;
    if (ph >= 0) begin
      er  = (ph == 0);
      ev  = (ph > 0) && (ph >= ce.lat) && (ph <= ce.lat + ct.d);
      erq = (ph > 0) && ce.mem && !ce.mis && (ph <= 1 + ct.w1);
      ers = (ph > 0) && ce.mem && !ce.mis && (ph >= 2 + ct.w1) && (ph < ce.lat);
      chk("o_ready", {31'h0, o_ready}, {31'h0, er});
      chk("o_valid", {31'h0, o_valid}, {31'h0, ev});
      chk("o_mem_req_valid", {31'h0, o_mem_req_valid}, {31'h0, erq});
      chk("o_mem_rsp_ready", {31'h0, o_mem_rsp_ready}, {31'h0, ers});
      if (erq) begin
        chk("o_mem_addr", o_mem_addr, ce.addr);
        chk("o_mem_wen", {31'h0, o_mem_wen}, {31'h0, ce.wen});
        if (ce.wen) begin
          chk("o_mem_wstrb", {28'h0, o_mem_wstrb}, {28'h0, ce.wstrb});
          chk("o_mem_wdata", o_mem_wdata, ce.wdata);
        end
      end
      if (ev) begin
        chk("o_rdata", o_rdata, ce.rdata);
        chk("o_fault", {31'h0, o_fault}, {31'h0, ce.fault});
        chk("o_ALUout", o_ALUout, ct.alu);
        chk("o_src1", o_src1, ct.src1);
        chk("o_imm", o_imm, ct.imm);
        chk("o_pc", o_pc, ct.pc);
        chk("o_inst", o_inst, ct.inst);
        chk("o_reg_ctl", {29'h0, o_reg_wena, o_reg_sel}, {29'h0, ct.wena, ct.sel});
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ready"}, {31'h0, o_ready}, 32'h1);
    chk({tag, "_ctl"}, {26'h0, o_valid, o_mem_req_valid, o_mem_rsp_ready, o_mem_wen,
                        o_fault, o_reg_wena}, 32'h0);
    chk({tag, "_wstrb_sel"}, {26'h0, o_mem_wstrb, o_reg_sel}, 32'h0);
    chk({tag, "_data"}, o_mem_addr | o_mem_wdata | o_ALUout | o_src1 | o_imm | o_pc
                        | o_inst | o_rdata, 32'h0);
  endtask

  task automatic clear_port_inputs();
    i_mem_req_ready = 1'b0; i_mem_rsp_valid = 1'b0; i_mem_rsp_err = 1'b0;
    i_mem_rdata = 32'h0; i_ready = 1'b0;
  endtask

  task automatic run_txn(input txn_t t);
    ct = t;
    ce = model(t);
    i_valid = 1'b1; i_ALUout = t.alu; i_src1 = t.src1; i_src2 = t.src2; i_imm = t.imm;
    i_pc = t.pc; i_inst = t.inst; i_reg_wena = t.wena; i_reg_sel = t.sel;
    i_MemWr = t.wr; i_MemRe = t.re; i_MemOp = t.op;
    @(posedge clk); #1;
    i_valid = 1'b0; i_ALUout = $urandom; i_src1 = $urandom; i_src2 = $urandom;
    i_imm = $urandom; i_pc = $urandom; i_inst = $urandom; i_MemOp = 3'($urandom);
    i_MemWr = 1'($urandom); i_MemRe = 1'($urandom);
    for (int p = 1; p <= 400; p++) begin
      ph = p;
      if (t.rst_at != 0 && p == t.rst_at) begin
        i_rst = 1'b1; ph = -1;
        @(posedge clk); #1;
        i_rst = 1'b0; clear_port_inputs();
        @(negedge clk);
        check_reset_outputs("mid_rst");
        @(posedge clk); #1;
        ph = 0;
        return;
      end
      i_mem_req_ready = (p >= 1 + t.w1);
      i_mem_rsp_valid = 1'b0;
      i_mem_rsp_err   = 1'($urandom);
      i_mem_rdata     = $urandom;
      if (ce.mem && !ce.mis && !(t.none || t.w2 >= TO) && p == 2 + t.w1 + t.w2) begin
        i_mem_rsp_valid = 1'b1; i_mem_rdata = t.rdata; i_mem_rsp_err = t.err;
      end else if (t.spur && p == 1 + t.w1) begin
        i_mem_rsp_valid = 1'b1;
      end
      i_ready = (p >= ce.lat + t.d);
      @(posedge clk); #1;
      if (p == ce.lat + t.d) break;
    end
    ph = 0;
    clear_port_inputs();
  endtask

  initial begin
    txn_t  t;
    exp_t  e;
    logic [2:0] ops [5];
    ops[0] = 3'b000; ops[1] = 3'b001; ops[2] = 3'b010; ops[3] = 3'b100; ops[4] = 3'b101;
    i_rst = 1'b1; i_valid = 1'b0; i_reg_wena = 1'b0; i_reg_sel = 2'd0;
    i_MemWr = 1'b0; i_MemRe = 1'b0; i_MemOp = 3'd0; i_ALUout = 32'h0; i_src1 = 32'h0;
    i_src2 = 32'h0; i_imm = 32'h0; i_pc = 32'h0; i_inst = 32'h0;
    clear_port_inputs();
    repeat (3) @(posedge clk);
    #1 i_rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    ph = 0;

    // Hand-computed anchors for the model itself.
    t = mk(32'h8000_0003, 1'b0, 1'b1, 3'b000); t.rdata = 32'h80FF_0000;
    e = model(t);
    chk("pin_lb_rdata", e.rdata, 32'hFFFF_FF80);
    chk("pin_lb_lat", e.lat, 32'd3);
    t.op = 3'b100; e = model(t);
    chk("pin_lbu_rdata", e.rdata, 32'h0000_0080);
    t = mk(32'h8000_0002, 1'b1, 1'b0, 3'b001); t.src2 = 32'hAAAA_BEEF; t.w1 = 2;
    e = model(t);
    chk("pin_sh_wstrb", {28'h0, e.wstrb}, 32'hC);
    chk("pin_sh_wdata", e.wdata, 32'hBEEF_BEEF);
    chk("pin_sh_lat", e.lat, 32'd5);

    // Directed cases.
    t = mk(32'h0000_1234, 1'b0, 1'b0, 3'b000); run_txn(t);
    t = mk(32'h8000_0003, 1'b0, 1'b1, 3'b000); t.rdata = 32'h80FF_0000; run_txn(t);
    t.op = 3'b100; run_txn(t);
    t = mk(32'h8000_0002, 1'b1, 1'b0, 3'b001); t.src2 = 32'hAAAA_BEEF; t.w1 = 2; run_txn(t);
    t = mk(32'h8000_0001, 1'b0, 1'b1, 3'b010); run_txn(t);
    t = mk(32'h8000_0010, 1'b0, 1'b1, 3'b010); t.none = 1'b1; t.rdata = 32'hDEAD_BEEF; run_txn(t);
    t = mk(32'h8000_0020, 1'b0, 1'b1, 3'b010); t.w2 = TO - 1; t.rdata = 32'h1234_5678; run_txn(t);
    t = mk(32'h0000_00C0, 1'b0, 1'b0, 3'b000); t.d = 3; run_txn(t);
    t = mk(32'h8000_0041, 1'b1, 1'b1, 3'b000); t.src2 = 32'h0000_005A; t.spur = 1'b1; run_txn(t);

    for (int n = 0; n < 80; n++) begin
      t = mk($urandom, 1'b0, 1'b0, 3'b000);
      t.wr = ($urandom_range(0, 2) == 0);
      t.re = t.wr ? 1'($urandom) : ($urandom_range(0, 3) != 0);
      t.op = t.wr ? ops[$urandom_range(0, 2)] : ops[$urandom_range(0, 4)];
      if ($urandom_range(0, 1) == 0) t.alu[1:0] = 2'b00;
      t.src1 = $urandom; t.src2 = $urandom; t.imm = $urandom; t.pc = $urandom;
      t.inst = $urandom; t.rdata = $urandom; t.wena = 1'($urandom); t.sel = 2'($urandom);
      t.err = ($urandom_range(0, 7) == 0);
      t.none = ($urandom_range(0, 15) == 0);
      t.spur = ($urandom_range(0, 3) == 0);
      t.w1 = $urandom_range(0, 2); t.w2 = $urandom_range(0, 5); t.d = $urandom_range(0, 2);
      run_txn(t);
      repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
    end

    // Reset while waiting for the response abandons the access.
    t = mk(32'h8000_0080, 1'b0, 1'b1, 3'b010); t.none = 1'b1; t.rst_at = 3; run_txn(t);
    t = mk(32'h0000_5678, 1'b0, 1'b0, 3'b000); run_txn(t);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
